// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (double-dabble, one bit per clock).
// Drives registered tens/ones digits; values above 99 show as 4'hF/4'hF (blank).
module bin_to_bcd_seq #(
    parameter int unsigned WIDTH = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_bin,
    output logic             in_ready,
    output logic [3:0]       tens,
    output logic [3:0]       ones,
    output logic             ovf,
    output logic             out_valid
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
    localparam int unsigned BCD_W = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [WIDTH-1:0]   sh_q;
    logic [WIDTH-1:0]   sh_new;
    logic [BCD_W-1:0]   bcd_q;
    logic [BCD_W-1:0]   bcd_adj;
    logic [BCD_W-1:0]   bcd_new;
    logic [CNT_W-1:0]   cnt_q;
    logic               ovf_pend_q;
    logic               accept;
    logic               last_shift;

    assign accept     = in_valid && (state_q == IDLE);
    assign last_shift = (state_q == SHIFT) && (cnt_q == CNT_W'(WIDTH - 1));

    // Add-3 correction on every nibble, evaluated on the pre-shift value, then shift.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 3; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        {bcd_new, sh_new} = {bcd_adj, sh_q} << 1;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = SHIFT;
            SHIFT:   if (last_shift) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register with handshake flags decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            in_ready  <= (state_d == IDLE);
            out_valid <= (state_d == DONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q       <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            tens       <= 4'd0;
            ones       <= 4'd0;
            ovf        <= 1'b0;
        end else begin
            if (accept) begin
                sh_q       <= in_bin;
                bcd_q      <= '0;
                cnt_q      <= '0;
                ovf_pend_q <= (32'(in_bin) > 32'd99);
            end else if (state_q == SHIFT) begin
                sh_q  <= sh_new;
                bcd_q <= bcd_new;
                cnt_q <= cnt_q + CNT_W'(1);
            end
            // Digits change only on the completing edge so the display never glitches.
            if (last_shift) begin
                tens <= ovf_pend_q ? 4'hF : bcd_new[7:4];
                ones <= ovf_pend_q ? 4'hF : bcd_new[3:0];
                ovf  <= ovf_pend_q;
            end
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: directed boundaries, full sweep and random values
// checked against a decimal-arithmetic reference model.
module tb_bin_to_bcd_seq;

    localparam int unsigned WIDTH = 7;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic [WIDTH-1:0] in_bin;
    logic             in_ready;
    logic [3:0]       tens;
    logic [3:0]       ones;
    logic             ovf;
    logic             out_valid;

    int errors = 0;
    int checks = 0;
    int last_t = 0;
    int last_o = 0;
    int last_v = 0;

    bin_to_bcd_seq #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_bin    (in_bin),
        .in_ready  (in_ready),
        .tens      (tens),
        .ones      (ones),
        .ovf       (ovf),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int ref_tens(input int v);
        return (v > 99) ? 15 : v / 10;
    endfunction

    function automatic int ref_ones(input int v);
        return (v > 99) ? 15 : v % 10;
    endfunction

    // One full transaction; in_bin is scrambled while busy to prove it is sampled once.
    task automatic convert(input int v);
        int  k;
        bit  seen;
        k = 0;
        @(negedge clk);
        while (!in_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("acc_ready", in_ready, 1);
        in_valid = 1'b1;
        in_bin   = WIDTH'(v);
        @(negedge clk);
        in_valid = 1'b0;
        check("busy_ready", in_ready, 0);
        seen = 1'b0;
        for (k = 1; k <= 2 * WIDTH && !seen; k++) begin
            in_bin = WIDTH'($urandom);
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                check("latency", k, WIDTH);
                check("tens", tens, ref_tens(v));
                check("ones", ones, ref_ones(v));
                check("ovf", ovf, (v > 99) ? 1 : 0);
                check("done_ready", in_ready, 0);
                last_t = ref_tens(v);
                last_o = ref_ones(v);
                last_v = (v > 99) ? 1 : 0;
            end else begin
                check("hold_tens", tens, last_t);
                check("hold_ones", ones, last_o);
                check("hold_ovf", ovf, last_v);
                check("busy_ready", in_ready, 0);
            end
        end
        if (!seen) check("out_valid_timeout", 0, 1);
        @(negedge clk);
        check("idle_ready", in_ready, 1);
        check("pulse_len", out_valid, 0);
    endtask

    initial begin
        int bounds[6];
        bounds = '{0, 9, 10, 99, 100, 127};
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_bin   = WIDTH'(55);

        // Reset held with in_valid asserted
        repeat (3) @(negedge clk);
        check("rst_tens", tens, 0);
        check("rst_ones", ones, 0);
        check("rst_ovf", ovf, 0);
        check("rst_valid", out_valid, 0);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(negedge clk);
        check("rst_ready", in_ready, 1);
        check("rst_idle_valid", out_valid, 0);

        convert(42);
        foreach (bounds[i]) convert(bounds[i]);

        // Idle hold: outputs keep the last result
        repeat (3) begin
            @(negedge clk);
            check("idle_tens", tens, last_t);
            check("idle_ones", ones, last_o);
        end

        for (int v = 0; v < 128; v++) convert(v);
        repeat (20) convert(int'($urandom_range(0, 127)));

        // in_valid held high: accepts only at E0 and E9
        @(negedge clk);
        in_valid = 1'b1;
        in_bin   = WIDTH'(7);
        for (int k = 0; k <= 17; k++) begin
            @(negedge clk);
            check("bb_ready", in_ready, (k == 8 || k == 17) ? 1 : 0);
            check("bb_valid", out_valid, (k == 7 || k == 16) ? 1 : 0);
            if (k == 7) begin
                check("bb_tens0", tens, 0);
                check("bb_ones0", ones, 7);
            end
            if (k == 16) begin
                check("bb_tens1", tens, 6);
                check("bb_ones1", ones, 3);
            end
            in_bin = (k < 6) ? WIDTH'(55) : WIDTH'(63);
            if (k == 17) in_valid = 1'b0;
        end
        last_t = 6;
        last_o = 3;
        last_v = 0;

        // Reset in the middle of converting 88
        @(negedge clk);
        in_valid = 1'b1;
        in_bin   = WIDTH'(88);
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_tens", tens, 0);
        check("arst_ones", ones, 0);
        check("arst_valid", out_valid, 0);
        repeat (2) begin
            @(negedge clk);
            check("arst_hold_valid", out_valid, 0);
        end
        rst_n  = 1'b1;
        last_t = 0;
        last_o = 0;
        last_v = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            check("arst_no_pulse", out_valid, 0);
        end
        convert(25);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
